ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage of the RISC-V pipeline, sitting directly upstream of the ALU. It captures decoded operands and control from ID and resolves RAW hazards by forwarding from MEM and WB. It drives the ALU's SrcA, SrcB and Operation inputs, and raises a load-use stall request toward the hazard logic.

---
 rtl/ex_operand_stage_pkg.sv | 42 ++++
 rtl/ex_operand_stage_if.sv | 60 ++++++
 rtl/ex_operand_stage_forwarding_unit.sv | 23 ++
 rtl/ex_operand_stage.sv | 100 ++++++++++
 tb/tb_ex_operand_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared pipeline definitions: ALU opcodes, forward-select encoding and the
// ID/EX register layout.
package pipeline_pkg;

  localparam int XLEN     = 32;
  localparam int OPC_LEN  = 4;
  localparam int RADDR_W  = 5;

  localparam logic [OPC_LEN-1:0] ALU_AND = 4'b0000;
  localparam logic [OPC_LEN-1:0] ALU_OR  = 4'b0001;
  localparam logic [OPC_LEN-1:0] ALU_ADD = 4'b0010;
  localparam logic [OPC_LEN-1:0] ALU_SLL = 4'b0100;
  localparam logic [OPC_LEN-1:0] ALU_SRL = 4'b0101;
  localparam logic [OPC_LEN-1:0] ALU_SUB = 4'b0110;
  localparam logic [OPC_LEN-1:0] ALU_SRA = 4'b0111;
  localparam logic [OPC_LEN-1:0] ALU_BEQ = 4'b1000;
  localparam logic [OPC_LEN-1:0] ALU_SLT = 4'b1100;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic               valid;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    imm;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [RADDR_W-1:0] rd_addr;
    logic               alu_src;
    logic               a_pc;
    logic [OPC_LEN-1:0] operation;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_if.sv
// ID/EX stage bus: decoded instruction from ID, MEM/WB forward sources,
// pipeline control and the ALU-facing outputs.
interface ex_operand_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [DATA_WIDTH-1:0]     id_rs1_data;
  logic [DATA_WIDTH-1:0]     id_rs2_data;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic                      id_alu_src;
  logic                      id_a_pc;
  logic [OPCODE_LENGTH-1:0]  id_operation;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      stall;
  logic                      flush;
  logic                      mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0]     mem_result;
  logic                      wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic [DATA_WIDTH-1:0]     wb_result;
  logic [DATA_WIDTH-1:0]     SrcA;
  logic [DATA_WIDTH-1:0]     SrcB;
  logic [OPCODE_LENGTH-1:0]  Operation;
  logic                      ex_valid;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic                      load_use_stall;

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_src, id_a_pc,
           id_operation, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    input  SrcA, SrcB, Operation, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd_addr, ex_store_data, load_use_stall
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_src, id_a_pc,
           id_operation, id_reg_write, id_mem_read, id_mem_write,
           stall, flush, mem_reg_write, mem_rd_addr, mem_result,
           wb_reg_write, wb_rd_addr, wb_result,
    output SrcA, SrcB, Operation, ex_valid, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_rd_addr, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/ex_operand_stage_forwarding_unit.sv
// Per-operand forward select: MEM beats WB, and x0 is never forwarded.
module forwarding_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] src_addr,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  output fwd_sel_e                  sel
);

  always_comb begin
    sel = FWD_REG;
    if (mem_reg_write && (mem_rd_addr == src_addr) && (mem_rd_addr != '0))
      sel = FWD_MEM;
    else if (wb_reg_write && (wb_rd_addr == src_addr) && (wb_rd_addr != '0))
      sel = FWD_WB;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// stall detection, feeding the ALU.
module ex_operand_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic              clk,
  input logic              reset_n,
  ex_operand_stage_if.slave bus
);

  id_ex_t                ex_q;
  id_ex_t                ex_d;
  fwd_sel_e              sel_rs1;
  fwd_sel_e              sel_rs2;
  logic [DATA_WIDTH-1:0] fwd_rs1;
  logic [DATA_WIDTH-1:0] fwd_rs2;

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs1 (
    .src_addr      (ex_q.rs1_addr),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .sel           (sel_rs1)
  );

  forwarding_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_rs2 (
    .src_addr      (ex_q.rs2_addr),
    .mem_reg_write (bus.mem_reg_write),
    .mem_rd_addr   (bus.mem_rd_addr),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_rd_addr    (bus.wb_rd_addr),
    .sel           (sel_rs2)
  );

  always_comb begin
    case (sel_rs1)
      FWD_MEM: fwd_rs1 = bus.mem_result;
      FWD_WB:  fwd_rs1 = bus.wb_result;
      default: fwd_rs1 = ex_q.rs1_data;
    endcase
    case (sel_rs2)
      FWD_MEM: fwd_rs2 = bus.mem_result;
      FWD_WB:  fwd_rs2 = bus.wb_result;
      default: fwd_rs2 = ex_q.rs2_data;
    endcase
  end

  // While stalled, latch the forwarded operands so a producer retiring out
  // of WB during the stall does not take its value with it.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (bus.stall) begin
      ex_d.rs1_data = fwd_rs1;
      ex_d.rs2_data = fwd_rs2;
    end else begin
      ex_d.valid     = bus.id_valid;
      ex_d.pc        = bus.id_pc;
      ex_d.imm       = bus.id_imm;
      ex_d.rs1_data  = bus.id_rs1_data;
      ex_d.rs2_data  = bus.id_rs2_data;
      ex_d.rs1_addr  = bus.id_rs1_addr;
      ex_d.rs2_addr  = bus.id_rs2_addr;
      ex_d.rd_addr   = bus.id_rd_addr;
      ex_d.alu_src   = bus.id_alu_src;
      ex_d.a_pc      = bus.id_a_pc;
      ex_d.operation = bus.id_operation;
      ex_d.reg_write = bus.id_reg_write;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.mem_write = bus.id_mem_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) ex_q <= '0;
    else          ex_q <= ex_d;
  end

  assign bus.SrcA          = ex_q.a_pc    ? ex_q.pc  : fwd_rs1;
  assign bus.SrcB          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign bus.ex_store_data = fwd_rs2;
  assign bus.Operation     = ex_q.operation;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_reg_write  = ex_q.valid & ex_q.reg_write;
  assign bus.ex_mem_read   = ex_q.valid & ex_q.mem_read;
  assign bus.ex_mem_write  = ex_q.valid & ex_q.mem_write;
  assign bus.ex_rd_addr    = ex_q.rd_addr;

  assign bus.load_use_stall = bus.id_valid & ex_q.valid & ex_q.mem_read &
                              (ex_q.rd_addr != '0) &
                              ((ex_q.rd_addr == bus.id_rs1_addr) |
                               (ex_q.rd_addr == bus.id_rs2_addr));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed vector table, hand-written stall/flush/
// load-use sequences, then random traffic against a behavioural model.
module tb_ex_operand_stage;
  import pipeline_pkg::*;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ex_operand_stage_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) bus();

  ex_operand_stage #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .REG_ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    bus.mem_reg_write = 1'b0; bus.mem_rd_addr = '0; bus.mem_result = '0;
    bus.wb_reg_write  = 1'b0; bus.wb_rd_addr  = '0; bus.wb_result  = '0;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic asrc, input logic apc, input logic [3:0] op,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_pc = pc; bus.id_imm = imm;
    bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_rs1_addr = r1; bus.id_rs2_addr = r2; bus.id_rd_addr = rd;
    bus.id_alu_src = asrc; bus.id_a_pc = apc; bus.id_operation = op;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
  endtask

  typedef struct {
    logic        apc, asrc;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  r1, r2;
    logic        mem_we; logic [4:0] mem_rd; logic [31:0] mem_res;
    logic        wb_we;  logic [4:0] wb_rd;  logic [31:0] wb_res;
    logic [31:0] exp_a, exp_b, exp_st;
  } vec_t;

  vec_t vecs[6];

  // Reference model of the EX register contents, kept as plain fields.
  typedef struct {
    logic        valid;
    logic [31:0] pc, imm, d1, d2;
    logic [4:0]  r1, r2, rd;
    logic        asrc, apc;
    logic [3:0]  op;
    logic        rw, mr, mw;
  } mdl_t;

  mdl_t m;

  function automatic logic [31:0] fwd_val(input logic [4:0] a, input logic [31:0] regv);
    if (a == 5'd0) return regv;
    if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_result;
    return regv;
  endfunction

  initial begin
    vecs[0] = '{0,0, 32'h0,  32'h0,  32'd5, 32'd7, 5'd1, 5'd2,
                0,5'd0,32'h0,  0,5'd0,32'h0,  32'd5, 32'd7, 32'd7};
    vecs[1] = '{0,0, 32'h0,  32'h0,  32'd1, 32'd2, 5'd3, 5'd4,
                1,5'd3,32'hAA, 1,5'd3,32'hBB, 32'hAA, 32'd2, 32'd2};
    vecs[2] = '{0,0, 32'h0,  32'h0,  32'd1, 32'd2, 5'd3, 5'd4,
                0,5'd3,32'hAA, 1,5'd3,32'hBB, 32'hBB, 32'd2, 32'd2};
    vecs[3] = '{0,0, 32'h0,  32'h0,  32'd9, 32'd0, 5'd6, 5'd0,
                1,5'd0,32'hFF, 1,5'd0,32'hEE, 32'd9, 32'd0, 32'd0};
    vecs[4] = '{1,1, 32'h100,32'h20, 32'd3, 32'd4, 5'd1, 5'd8,
                0,5'd0,32'h0,  1,5'd8,32'h55, 32'h100, 32'h20, 32'h55};
    vecs[5] = '{0,0, 32'h0,  32'h0,  32'd3, 32'd4, 5'd9, 5'd9,
                1,5'd9,32'h11, 1,5'd9,32'h22, 32'h11, 32'h11, 32'h11};

    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    clear_fwd();
    bus.stall = 1'b0; bus.flush = 1'b0;

    // Reset and first capture
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1; #1;
    check("rst_srca", bus.SrcA, 0);
    check("rst_srcb", bus.SrcB, 0);
    check("rst_op", bus.Operation, 0);
    check("rst_valid", bus.ex_valid, 0);
    check("rst_lus", bus.load_use_stall, 0);
    set_id(1, 0, 0, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 0, 0, ALU_ADD, 1, 0, 0);
    tick();
    check("add_srca", bus.SrcA, 32'd5);
    check("add_srcb", bus.SrcB, 32'd7);
    check("add_op", bus.Operation, {28'd0, ALU_ADD});
    check("add_valid", bus.ex_valid, 1);

    // Forwarding vector table
    for (int i = 0; i < 6; i++) begin
      clear_fwd();
      set_id(1, vecs[i].pc, vecs[i].imm, vecs[i].d1, vecs[i].d2, vecs[i].r1, vecs[i].r2,
             5'd10, vecs[i].asrc, vecs[i].apc, ALU_OR, 1, 0, 0);
      tick();
      bus.id_valid = 1'b0;
      bus.mem_reg_write = vecs[i].mem_we; bus.mem_rd_addr = vecs[i].mem_rd;
      bus.mem_result = vecs[i].mem_res;
      bus.wb_reg_write = vecs[i].wb_we; bus.wb_rd_addr = vecs[i].wb_rd;
      bus.wb_result = vecs[i].wb_res;
      #1;
      check($sformatf("vec%0d_srca", i), bus.SrcA, vecs[i].exp_a);
      check($sformatf("vec%0d_srcb", i), bus.SrcB, vecs[i].exp_b);
      check($sformatf("vec%0d_store", i), bus.ex_store_data, vecs[i].exp_st);
    end
    clear_fwd();

    // Stall with WB retiring mid-stall
    set_id(1, 0, 0, 32'd0, 32'd0, 5'd5, 5'd6, 5'd1, 0, 0, ALU_ADD, 1, 0, 0);
    tick();
    set_id(1, 0, 0, 32'hDEAD, 32'd0, 5'd1, 5'd2, 5'd2, 0, 0, ALU_SUB, 1, 0, 0);
    bus.wb_reg_write = 1'b1; bus.wb_rd_addr = 5'd5; bus.wb_result = 32'h1234;
    bus.stall = 1'b1;
    #1 check("stall_c0_srca", bus.SrcA, 32'h1234);
    tick();
    bus.wb_reg_write = 1'b0;
    #1 check("stall_c1_srca", bus.SrcA, 32'h1234);
    check("stall_c1_op", bus.Operation, {28'd0, ALU_ADD});
    tick();
    check("stall_c2_srca", bus.SrcA, 32'h1234);
    tick();
    bus.stall = 1'b0;
    #1 check("stall_rel_srca", bus.SrcA, 32'h1234);
    check("stall_rel_rd", bus.ex_rd_addr, 5'd1);
    tick();
    check("post_stall_srca", bus.SrcA, 32'hDEAD);
    check("post_stall_op", bus.Operation, {28'd0, ALU_SUB});
    clear_fwd();

    // Flush beats stall
    set_id(1, 0, 0, 1, 2, 5'd1, 5'd2, 5'd4, 0, 0, ALU_ADD, 1, 0, 1);
    tick();
    check("pre_flush_mw", bus.ex_mem_write, 1);
    bus.flush = 1'b1; bus.stall = 1'b1;
    tick();
    bus.flush = 1'b0; bus.stall = 1'b0;
    check("flush_valid", bus.ex_valid, 0);
    check("flush_rw", bus.ex_reg_write, 0);
    check("flush_mw", bus.ex_mem_write, 0);

    // Load-use detection
    set_id(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd7, 1, 0, ALU_ADD, 1, 1, 0);
    tick();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd1; bus.id_rs2_addr = 5'd7;
    #1 check("lu_rs2", bus.load_use_stall, 1);
    bus.id_valid = 1'b0;
    #1 check("lu_idinvalid", bus.load_use_stall, 0);
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd7; bus.id_rs2_addr = 5'd2;
    #1 check("lu_rs1", bus.load_use_stall, 1);
    set_id(1, 0, 0, 0, 0, 5'd1, 5'd2, 5'd0, 1, 0, ALU_ADD, 1, 1, 0);
    tick();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd3; bus.id_rs2_addr = 5'd0;
    #1 check("lu_rd_x0", bus.load_use_stall, 0);
    set_id(0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd7, 1, 0, ALU_ADD, 1, 1, 0);
    tick();
    bus.id_valid = 1'b1; bus.id_rs1_addr = 5'd3; bus.id_rs2_addr = 5'd7;
    #1 check("lu_exinvalid", bus.load_use_stall, 0);
    check("gated_mr", bus.ex_mem_read, 0);

    // Reset wins over stall
    set_id(1, 32'h40, 0, 32'd8, 0, 5'd1, 5'd2, 5'd3, 0, 1, ALU_SLT, 1, 0, 0);
    tick();
    check("pre_rst_srca", bus.SrcA, 32'h40);
    bus.stall = 1'b1; reset_n = 1'b0;
    tick();
    reset_n = 1'b1; bus.stall = 1'b0;
    check("rst_stall_valid", bus.ex_valid, 0);
    check("rst_stall_srca", bus.SrcA, 0);
    check("rst_stall_op", bus.Operation, 0);

    // Random traffic against the model
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    m = '{default: '0};
    for (int i = 0; i < 400; i++) begin
      reset_n   = ($urandom_range(0, 49) != 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      set_id($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.mem_reg_write = $urandom_range(0, 1); bus.mem_rd_addr = 5'($urandom_range(0, 3));
      bus.mem_result = $urandom;
      bus.wb_reg_write = $urandom_range(0, 1); bus.wb_rd_addr = 5'($urandom_range(0, 3));
      bus.wb_result = $urandom;
      #1;
      check("rnd_srca", bus.SrcA, m.apc ? m.pc : fwd_val(m.r1, m.d1));
      check("rnd_srcb", bus.SrcB, m.asrc ? m.imm : fwd_val(m.r2, m.d2));
      check("rnd_store", bus.ex_store_data, fwd_val(m.r2, m.d2));
      check("rnd_op", bus.Operation, {28'd0, m.op});
      check("rnd_valid", bus.ex_valid, m.valid);
      check("rnd_rw", bus.ex_reg_write, m.valid && m.rw);
      check("rnd_mr", bus.ex_mem_read, m.valid && m.mr);
      check("rnd_mw", bus.ex_mem_write, m.valid && m.mw);
      check("rnd_rd", bus.ex_rd_addr, m.rd);
      check("rnd_lus", bus.load_use_stall,
            bus.id_valid && m.valid && m.mr && m.rd != 0 &&
            (m.rd == bus.id_rs1_addr || m.rd == bus.id_rs2_addr));
      if (!reset_n || bus.flush) begin
        m = '{default: '0};
      end else if (bus.stall) begin
        m.d1 = fwd_val(m.r1, m.d1);
        m.d2 = fwd_val(m.r2, m.d2);
      end else begin
        m.valid = bus.id_valid; m.pc = bus.id_pc; m.imm = bus.id_imm;
        m.d1 = bus.id_rs1_data; m.d2 = bus.id_rs2_data;
        m.r1 = bus.id_rs1_addr; m.r2 = bus.id_rs2_addr; m.rd = bus.id_rd_addr;
        m.asrc = bus.id_alu_src; m.apc = bus.id_a_pc; m.op = bus.id_operation;
        m.rw = bus.id_reg_write; m.mr = bus.id_mem_read; m.mw = bus.id_mem_write;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
